// File: rtl/cap_mem_responder129.sv
// cap_mem_responder129: 129-bit capability memory responder with fixed-latency responses; CAP_MEM_COMP_WAIT_EN enables the comp_mode latency.
module cap_mem_responder129 #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_BASE   = 4,
    parameter int WAIT_COMP   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [31:0]  req_addr,
    input  logic [128:0] req_wdata,
    input  logic         comp_mode,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [128:0] rsp_rdata,
    output logic         rsp_err,
    output logic         busy,
    output logic [31:0]  txn_cnt
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [31:0] cnt, addr_q, n, c_addr;
    logic we_q, c_we, c_err, commit, unused_ok;
    logic [128:0] wdata_q, c_wdata;
    logic [AW-1:0] c_idx;
    logic [128:0] mem [DEPTH_WORDS] = '{default: '0};
`ifdef CAP_MEM_COMP_WAIT_EN
    assign n = comp_mode ? 32'(WAIT_COMP) : 32'(WAIT_BASE);
`else
    assign n = 32'(WAIT_BASE);
`endif
    assign unused_ok = comp_mode | (WAIT_COMP == 0);
    // In IDLE the live request is used so that N=1 can commit on the accepting edge.
    assign c_we    = state == IDLE ? req_we : we_q;
    assign c_addr  = state == IDLE ? req_addr : addr_q;
    assign c_wdata = state == IDLE ? req_wdata : wdata_q;
    assign c_err   = c_addr[3:0] != 4'd0 || c_addr >= 32'(DEPTH_WORDS * 16);
    assign c_idx   = c_addr[AW+3:4];
    assign commit  = state == IDLE ? (req_valid && n == 32'd1) : (state == WAIT && cnt == 32'd1);
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk)
        if (rst_n && commit && c_we && !c_err) mem[c_idx] <= c_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            txn_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cnt     <= n - 32'd1;
                    state   <= n == 32'd1 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 32'd1;
                    if (cnt == 32'd1) state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    txn_cnt   <= txn_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= c_err;
                rsp_rdata <= (c_we || c_err) ? '0 : mem[c_idx];
            end
        end
    end
endmodule

// File: tb/tb_cap_mem_responder129.sv
// tb_cap_mem_responder129: table-driven and randomized checks of cap_mem_responder129 against a word-array model.
module tb_cap_mem_responder129;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, comp_mode = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [128:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, busy;
    logic [128:0] rsp_rdata;
    logic [31:0] txn_cnt;
    int errors = 0, checks = 0;
    logic [31:0] exp_txn = '0;
    logic [128:0] mm [64];
    logic [128:0] rd, wd, old30;
    logic e, we, comp;
    logic [31:0] addr;

    cap_mem_responder129 dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .comp_mode(comp_mode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .txn_cnt(txn_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic we; logic [31:0] addr; logic [128:0] wd; logic comp; int hold;
        logic err; logic [128:0] rd;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory of 16-byte granules; anything misaligned or beyond 1 KiB is an error.
    function automatic void model(input logic w, input logic [31:0] a, input logic [128:0] d,
                                  output logic [128:0] r, output logic er);
        er = (a % 16 != 0) || (a >= 64 * 16);
        r = '0;
        if (!er) begin
            if (w) mm[a / 16] = d;
            else r = mm[a / 16];
        end
    endfunction

    function automatic int lat_of(input logic c);
`ifdef CAP_MEM_COMP_WAIT_EN
        return c ? 3 : 4;
`else
        return 4;
`endif
    endfunction

    function automatic logic [128:0] rnd129();
        return {1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic txn(input logic w, input logic [31:0] a, input logic [128:0] d, input logic c,
                       input int hold, input logic [128:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = d; comp_mode = c;
        rsp_ready = (hold == 0);
        chk("req_ready_idle", 129'(req_ready), 129'(1));
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom();
        req_wdata = rnd129(); comp_mode = ~c;
        chk("busy_after_accept", 129'(busy), 129'(1));
        lat = 1;
        while (!rsp_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 129'(lat), 129'(lat_of(c)));
        chk("rsp_err", 129'(rsp_err), 129'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 129'(rsp_valid), 129'(1));
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 129'(rsp_err), 129'(exp_err));
            chk("hold_ready_busy", {127'(0), req_ready, busy}, 129'(2'b01));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_txn++;
        chk("post_hs_state", {127'(0), rsp_valid, req_ready}, 129'(2'b01));
        chk("txn_cnt", 129'(txn_cnt), 129'(exp_txn));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 129'(req_ready), 129'(1));
        chk("rst_rsp_valid", 129'(rsp_valid), 129'(0));
        chk("rst_rsp_err", 129'(rsp_err), 129'(0));
        chk("rst_rsp_rdata", rsp_rdata, 129'(0));
        chk("rst_busy", 129'(busy), 129'(0));
        chk("rst_txn_cnt", 129'(txn_cnt), 129'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mm[i] = '0;
        tbl[0]  = '{1'b1, 32'h20,       {1'b1, 128'hA5},        1'b0, 0, 1'b0, '0};
        tbl[1]  = '{1'b0, 32'h20,       '0,                     1'b1, 0, 1'b0, {1'b1, 128'hA5}};
        tbl[2]  = '{1'b1, 32'h24,       {1'b0, {128{1'b1}}},    1'b0, 0, 1'b1, '0};
        tbl[3]  = '{1'b1, 32'h400,      {1'b1, 128'h123},       1'b0, 0, 1'b1, '0};
        tbl[4]  = '{1'b0, 32'h20,       '0,                     1'b0, 2, 1'b0, {1'b1, 128'hA5}};
        tbl[5]  = '{1'b0, 32'h0,        '0,                     1'b1, 0, 1'b0, '0};
        tbl[6]  = '{1'b0, 32'h24,       '0,                     1'b0, 0, 1'b1, '0};
        tbl[7]  = '{1'b1, 32'h3F0,      {1'b0, 128'hDEADBEEF},  1'b1, 5, 1'b0, '0};
        tbl[8]  = '{1'b1, 32'hFFFFFFF0, {1'b1, 128'h0},         1'b0, 1, 1'b1, '0};
        tbl[9]  = '{1'b0, 32'h3F0,      '0,                     1'b0, 0, 1'b0, {1'b0, 128'hDEADBEEF}};
        tbl[10] = '{1'b0, 32'h10,       '0,                     1'b1, 0, 1'b0, '0};
        tbl[11] = '{1'b1, 32'h30,       {1'b1, 128'h3030},      1'b0, 0, 1'b0, '0};
        tbl[12] = '{1'b0, 32'h30,       '0,                     1'b0, 3, 1'b0, {1'b1, 128'h3030}};
        tbl[13] = '{1'b0, 32'h1000,     '0,                     1'b1, 0, 1'b1, '0};
        #2;
        chk_reset_vals();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].wd, rd, e);
            txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].comp, tbl[i].hold, tbl[i].rd, tbl[i].err);
        end
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            addr = 32'($urandom_range(0, 63)) * 16;
            if (r == 7) addr = addr + 32'($urandom_range(1, 15));
            if (r >= 8) addr = $urandom() | 32'h400;
            we = 1'($urandom_range(0, 1));
            comp = 1'($urandom_range(0, 1));
            wd = rnd129();
            model(we, addr, wd, rd, e);
            txn(we, addr, wd, comp, $urandom_range(0, 3), rd, e);
        end
        // Reset two cycles into a write to 0x30 must drop that write.
        old30 = mm[3];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = ~old30; comp_mode = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        exp_txn = '0;
        txn(1'b0, 32'h30, '0, 1'b0, 0, old30, 1'b0);
        @(negedge clk);
        force dut.txn_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.txn_cnt;
        exp_txn = 32'hFFFF_FFFF;
        model(1'b0, 32'h20, '0, rd, e);
        txn(1'b0, 32'h20, '0, 1'b1, 1, rd, e);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cap_mem_responder129.md
CAP_MEM_RESPONDER129 -- requirements
Module: cap_mem_responder129

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 129-bit storage words, power of two, >= 2.
REQ-002 SHALL have parameter WAIT_BASE, default 4, response latency in cycles with comp_mode=0, >= 1.
REQ-003 SHALL have parameter WAIT_COMP, default 3, response latency in cycles with comp_mode=1 (only when the Configuration macro is defined), >= 1.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1, 1 means write, 0 means read.
REQ-009 SHALL have port req_addr, input, 32, byte address.
REQ-010 SHALL have port req_wdata, input, 129, write capability; bit 128 is the tag.
REQ-011 SHALL have port comp_mode, input, 1, compressed-capability mode select.
REQ-012 SHALL have port rsp_valid, output, 1, response available.
REQ-013 SHALL have port rsp_ready, input, 1, initiator accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 129, read data; 0 for writes and errors.
REQ-015 SHALL have port rsp_err, output, 1, misaligned or out-of-range access.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-017 SHALL have port txn_cnt, output, 32, completed-response counter.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge with req_valid & req_ready, and SHALL latch req_we, req_addr, req_wdata and the selected latency N at that edge.
REQ-020 SHALL raise rsp_valid after exactly N rising edges counted from the accepting edge, so the accepting edge is edge 1 and rsp_valid is high after edge N.
REQ-021 SHALL move IDLE->WAIT on accept when N>1, and SHALL move IDLE->RESP directly when N=1.
REQ-022 SHALL move WAIT->RESP on the edge that completes the Nth cycle.
REQ-023 SHALL compute word index as addr[log2(DEPTH_WORDS)+3:4], giving 16-byte granules.
REQ-024 SHALL flag an error when addr[3:0]!=0 or addr>=DEPTH_WORDS*16.
REQ-025 SHALL perform the memory write, or sample the read data, on the edge entering RESP.
REQ-026 On error: no memory write, rsp_err=1, rsp_rdata=0.
REQ-027 SHALL store and return all 129 bits unchanged, including tag bit 128.
REQ-028 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid & rsp_ready.
REQ-029 On handshake: RESP->IDLE; txn_cnt increments by 1, wrapping 0xFFFFFFFF->0.
REQ-030 req_ready SHALL be 0 in the handshake cycle; the next accept is possible no earlier than the following edge.
REQ-031 rsp_ready held high before rsp_valid SHALL have no effect.
REQ-032 Changes on req_* and comp_mode outside the accepting edge SHALL have no effect.
REQ-033 Reads of never-written words SHALL return 0; storage SHALL be zero-initialised at time zero.

Reset
REQ-034 rst_n low SHALL immediately force: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, txn_cnt=0.
REQ-035 Reset asserted in WAIT or RESP SHALL abort the transaction; a pending write not yet committed SHALL be dropped.
REQ-036 Storage contents SHALL be unaffected by reset.
REQ-037 Reset deassertion SHALL take effect at the next rising edge; the first accept is possible on that edge.

Configuration
REQ-038 SHALL use macro CAP_MEM_COMP_WAIT_EN.
REQ-039 With CAP_MEM_COMP_WAIT_EN defined: N = comp_mode ? WAIT_COMP : WAIT_BASE.
REQ-040 With CAP_MEM_COMP_WAIT_EN undefined: N = WAIT_BASE, and comp_mode SHALL be ignored.

Verification
REQ-041 Write addr 0x20, wdata {1'b1,128'hA5}, comp_mode=0, rsp_ready=1 -> rsp_valid high after edge 4, rsp_err=0, rsp_rdata=0; read of 0x20 then returns {1'b1,128'hA5} with tag 1.
REQ-042 With CAP_MEM_COMP_WAIT_EN defined, read with comp_mode=1 -> rsp_valid after edge 3; with the macro undefined, the same stimulus -> rsp_valid after edge 4.
REQ-043 Write addr 0x24 (misaligned) and write addr 0x400 (out of range, DEPTH_WORDS=64) -> rsp_err=1, rsp_rdata=0; the target words remain unchanged on readback.
REQ-044 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, busy=1; release -> IDLE, txn_cnt +1.
REQ-045 Pull rst_n low two cycles after accepting a write to 0x30 -> outputs immediately at reset values; readback of 0x30 returns its prior value.
REQ-046 Preload txn_cnt to 0xFFFFFFFF via 2^32-1 handshakes or a forced value, then complete one response -> txn_cnt=0.
